// File: rtl/gemm_seq.sv
// Sequencer for a chain of NCORE weight-stationary MAC cores: loads weights, streams
// eight activations, waits out the MAC pipeline, then shifts results off the chain tail.
module gemm_seq #(
  parameter int NCORE = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_reload,
  output logic             o_busy,
  output logic             o_done,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_data,
  output logic             o_out_last,
  output logic             o_init,
  output logic             o_exec,
  output logic             o_outr,
  output logic             o_update,
  output logic [NCORE-1:0] o_write,
  output logic [2:0]       o_ra,
  output logic [2:0]       o_wa,
  output logic [31:0]      o_wd,
  output logic [31:0]      o_d,
  input  logic [31:0]      i_acc_chain
);
  localparam int CW = $clog2(8*NCORE);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(8*NCORE-1);
  localparam logic [CW-1:0] EXEC_LAST  = CW'(7);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2);
  localparam logic [CW-1:0] OUT_LAST   = CW'(NCORE-1);

  typedef enum logic [2:0] {IDLE, LOAD, INIT, EXEC, DRAIN, OUT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [31:0]   r_d;

  logic          w_in_acc;
  logic          w_out_acc;
  logic [CW-1:0] w_core;

  assign o_in_ready  = (r_state == LOAD) || (r_state == EXEC);
  assign w_in_acc    = o_in_ready && i_in_valid;
  assign o_out_valid = (r_state == OUT);
  assign w_out_acc   = o_out_valid && i_out_ready;

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_d        = r_d;
  assign o_init     = (r_state == INIT);
  assign o_exec     = (r_state == EXEC) && w_in_acc;
  assign o_ra       = (r_state == EXEC) ? r_cnt[2:0] : 3'd0;
  assign o_wa       = (r_state == LOAD) ? r_cnt[2:0] : 3'd0;
  assign o_wd       = (r_state == LOAD) ? i_in_data : 32'd0;
  assign o_out_data = o_out_valid ? i_acc_chain : 32'd0;
  assign o_out_last = o_out_valid && (r_cnt == OUT_LAST);
  // Results are latched into the cores' shift path only while the first word is presented.
  assign o_update   = o_out_valid && (r_cnt == '0);
  assign o_outr     = w_out_acc;

  assign w_core = r_cnt >> 3;

  always_comb begin
    o_write = '0;
    for (int c = 0; c < NCORE; c++)
      o_write[c] = (r_state == LOAD) && w_in_acc && (w_core == CW'(c));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_busy  <= 1'b1;
          r_cnt   <= '0;
          r_state <= i_reload ? LOAD : INIT;
        end
        LOAD: if (w_in_acc) begin
          if (r_cnt == LOAD_LAST) begin
            r_cnt   <= '0;
            r_state <= INIT;
          end else r_cnt <= r_cnt + 1'b1;
        end
        INIT: begin
          r_cnt   <= '0;
          r_state <= EXEC;
        end
        EXEC: if (w_in_acc) begin
          r_d <= i_in_data;
          if (r_cnt == EXEC_LAST) begin
            r_cnt   <= '0;
            r_state <= DRAIN;
          end else r_cnt <= r_cnt + 1'b1;
        end
        // Covers the cores' three-stage MAC pipeline before results are read.
        DRAIN: begin
          if (r_cnt == DRAIN_LAST) begin
            r_cnt   <= '0;
            r_state <= OUT;
          end else r_cnt <= r_cnt + 1'b1;
        end
        OUT: if (w_out_acc) begin
          if (r_cnt == OUT_LAST) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gemm_seq.sv
// Directed bench for gemm_seq with a behavioural MAC-core chain driving acc_chain.
module tb_gemm_seq;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset, start, reload, in_valid, out_ready;
  logic [31:0] in_data, acc_chain;
  logic busy, done, in_ready, out_valid, out_last, init, exec, outr, update;
  logic [31:0] out_data, wd, d;
  logic [N-1:0] write;
  logic [2:0] ra, wa;

  int checks = 0, failures = 0;
  int wr_cnt = 0, ex_cnt = 0, viol = 0;

  always #5 clk = ~clk;

  gemm_seq #(.NCORE(N)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_reload(reload),
    .o_busy(busy), .o_done(done),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data), .o_out_last(out_last),
    .o_init(init), .o_exec(exec), .o_outr(outr), .o_update(update),
    .o_write(write), .o_ra(ra), .o_wa(wa), .o_wd(wd), .o_d(d),
    .i_acc_chain(acc_chain)
  );

  // Core chain model: weight RAM, accumulator fed one cycle after exec, shift path.
  logic [31:0] wmem [N][8];
  logic [31:0] acc [N];
  logic [31:0] sh  [N];
  logic        pend = 1'b0;
  logic [2:0]  pend_ra = 3'd0;

  always @(posedge clk) begin
    for (int c = 0; c < N; c++) if (write[c]) wmem[c][wa] <= wd;
    pend    <= exec;
    pend_ra <= ra;
    for (int c = 0; c < N; c++)
      if (init) acc[c] <= 32'd0;
      else if (pend) acc[c] <= acc[c] + wmem[c][pend_ra] * d;
    if (update && outr) begin
      sh[0] <= 32'd0;
      for (int c = 1; c < N; c++) sh[c] <= acc[c-1];
    end else if (update) begin
      for (int c = 0; c < N; c++) sh[c] <= acc[c];
    end else if (outr) begin
      sh[0] <= 32'd0;
      for (int c = 1; c < N; c++) sh[c] <= sh[c-1];
    end
  end
  assign acc_chain = update ? acc[N-1] : sh[N-1];

  // Protocol monitor.
  logic        p_exec = 1'b0;
  logic [31:0] p_data = 32'd0, p_d = 32'd0;
  always @(negedge clk) begin
    if (!reset) begin
      if (p_exec && d != p_data) viol++;
      if (!p_exec && d != p_d) viol++;
      if ($countones(write) > 1) viol++;
      if ((int'(|write) + int'(exec) + int'(init)) > 1) viol++;
      if ((|write || exec) && !(in_valid && in_ready)) viol++;
      if (!busy && (|write || exec || init || outr || update)) viol++;
      wr_cnt += $countones(write);
      if (exec) ex_cnt++;
      p_exec = exec; p_data = in_data; p_d = d;
    end else begin
      p_exec = 1'b0; p_d = 32'd0;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    #1;
    chk("reset_outputs", (|{busy, done, init, exec, outr, update, write, ra, wa, wd, d,
                           in_ready, out_valid, out_last, out_data}) ? 1 : 0, 0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
  endtask

  task automatic feed(input logic [31:0] w, input bit tog);
    int t = 0;
    if (tog) begin in_valid = 1'b0; @(posedge clk); #1; end
    in_valid = 1'b1; in_data = w; #1;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_pass(input bit rl, input int a0, input bit tog, input bit ostall,
                          input bit spur, input int abort_load, input int abort_out,
                          input int exp0, input int step, input int exp_wr);
    int t;
    wr_cnt = 0; ex_cnt = 0;
    start = 1'b1; reload = rl;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (rl)
      for (int k = 0; k < 8*N; k++) begin
        if (k == abort_load) begin do_reset(); return; end
        feed((k % 8 == 0) ? 32'(k/8 + 1) : 32'd0, tog);
      end
    for (int j = 0; j < 8; j++) begin
      if (spur && j == 3) start = 1'b1;
      feed((j == 0) ? 32'(a0) : 32'd0, tog);
      start = 1'b0;
    end
    chk("exec_count", ex_cnt, 8);
    chk("write_count", wr_cnt, exp_wr);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == abort_out) begin do_reset(); return; end
      t = 0;
      while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
      if (t >= 20) begin chk("out_valid_timeout", 0, 1); return; end
      if (ostall && (i == 0 || i == 3)) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          chk("stall_outr", outr, 0);
          chk("stall_data", out_data, exp0 - i*step);
          chk("stall_update", update, (i == 0) ? 1 : 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      #1;
      chk("out_data", out_data, exp0 - i*step);
      chk("out_last", out_last, (i == N-1) ? 1 : 0);
      chk("update", update, (i == 0) ? 1 : 0);
      chk("outr", outr, 1);
      @(posedge clk); #1;
    end
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    @(posedge clk); #1;
    chk("done_clear", done, 0);
    chk("idle_after_pass", busy, 0);
  endtask

  typedef struct {
    bit rl; int a0; bit tog; int exp0; int step; int wr;
  } vec_t;

  vec_t tbl [3];

  initial begin
    tbl[0] = '{rl: 1'b1, a0: 5, tog: 1'b0, exp0: 40, step: 5, wr: 64};
    tbl[1] = '{rl: 1'b0, a0: 2, tog: 1'b0, exp0: 16, step: 2, wr: 0};
    tbl[2] = '{rl: 1'b1, a0: 5, tog: 1'b1, exp0: 40, step: 5, wr: 64};

    reset = 1'b1; start = 1'b0; reload = 1'b0; in_valid = 1'b0;
    in_data = 32'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", (|{busy, done, init, exec, outr, update, write, ra, wa, wd, d,
                           in_ready, out_valid, out_last, out_data}) ? 1 : 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++)
      run_pass(tbl[i].rl, tbl[i].a0, tbl[i].tog, 1'b0, 1'b0, -1, -1,
               tbl[i].exp0, tbl[i].step, tbl[i].wr);

    run_pass(1'b0, 5, 1'b0, 1'b1, 1'b0, -1, -1, 40, 5, 0);
    run_pass(1'b0, 2, 1'b0, 1'b0, 1'b1, -1, -1, 16, 2, 0);
    run_pass(1'b1, 5, 1'b0, 1'b0, 1'b0, 20, -1, 40, 5, 64);
    run_pass(1'b1, 5, 1'b0, 1'b0, 1'b0, -1, -1, 40, 5, 64);
    run_pass(1'b0, 5, 1'b0, 1'b0, 1'b0, -1, 2, 40, 5, 0);
    run_pass(1'b1, 5, 1'b0, 1'b0, 1'b0, -1, -1, 40, 5, 64);

    chk("protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gemm_seq.md
GEMM_SEQ -- requirements
Module: gemm_seq

Interface
REQ-001 Parameter NCORE, default 8: number of MAC cores on the chain; each core holds 8 weight words.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to run one GEMM pass.
REQ-005 reload  input  1  sampled with start: 1 = load weights first, 0 = reuse resident weights.
REQ-006 busy, done  output  1 each  busy high from accepted start to end of pass; done pulses one cycle at end of pass.
REQ-007 in_valid, in_ready, in_data  input/output/input  1/1/32  weight and activation stream.
REQ-008 out_valid, out_ready, out_data, out_last  output/input/output/output  1/1/32/1  result stream.
REQ-009 init, exec, outr, update  output  1 each  core command strobes, broadcast to all cores.
REQ-010 write  output  NCORE  one-hot per-core weight write enable.
REQ-011 ra, wa  output  3 each  core read and write addresses.
REQ-012 wd, d  output  32 each  weight write data and activation data.
REQ-013 acc_chain  input  32  acc output of core NCORE-1, the chain tail.

Function
REQ-014 States SHALL be IDLE, LOAD, INIT, EXEC, DRAIN, OUT.
REQ-015 IDLE: start=1 SHALL go to LOAD if reload=1, else INIT; start is ignored while busy.
REQ-016 LOAD: in_ready=1; the k-th accepted word (k = 0..8*NCORE-1) SHALL assert write[k/8] with wa=k%8 and wd=in_data, combinationally in the accept cycle.
REQ-017 After word 8*NCORE-1 is accepted, the block SHALL go to INIT.
REQ-018 INIT SHALL last exactly one cycle with init=1 and in_ready=0, then go to EXEC.
REQ-019 EXEC: in_ready=1; the j-th accepted word (j = 0..7) SHALL assert exec=1 with ra=j in the accept cycle.
REQ-020 EXEC: d SHALL be registered and equal that word in the following cycle, matching the core's one-cycle operand capture.
REQ-021 d SHALL hold its value when no word is accepted; stalls in in_valid SHALL insert exec=0 bubbles only.
REQ-022 After word 7 is accepted, the block SHALL go to DRAIN and wait exactly 3 cycles (core MAC pipeline depth), in_ready=0, then go to OUT.
REQ-023 OUT: out_valid=1 and out_data=acc_chain, combinationally.
REQ-024 OUT: update=1 while output count=0, else update=0.
REQ-025 OUT: outr SHALL equal out_valid&out_ready.
REQ-026 OUT: word 0 SHALL be core NCORE-1's accumulator, word i SHALL be core NCORE-1-i's accumulator.
REQ-027 OUT: out_last=1 on word NCORE-1; its acceptance SHALL go to IDLE and pulse done in the next cycle.
REQ-028 out_ready=0 SHALL hold outr=0 and all state; out_data SHALL stay stable while out_valid=1 and not accepted.
REQ-029 write, exec and init SHALL never be asserted in the same cycle; all strobes SHALL be 0 in IDLE.
REQ-030 Counters SHALL be sized ceil(log2(8*NCORE)) bits and SHALL clear on state entry; no wrap occurs within a state.

Reset
REQ-031 On reset: state=IDLE, busy=0, done=0, all strobes and write=0, ra=wa=0, d=wd=0, in_ready=0, out_valid=0, out_last=0, all counters=0.
REQ-032 Reset asserted mid-pass SHALL abort immediately with no further strobes.
REQ-033 After a mid-pass reset, core weights are undefined, so the next start SHALL use reload=1.

Verification
REQ-034 NCORE=8, reload=1, weight core c addr 0 = c+1, others 0; activations 5,0,0,0,0,0,0,0 -> out_data 40,35,30,25,20,15,10,5, out_last on 5, done one cycle later.
REQ-035 Repeat with reload=0 and activations 2,0... -> 16,14,...,2; no write pulses observed.
REQ-036 in_valid toggled every other cycle in LOAD and EXEC -> same results as REQ-034, write/exec only on accept cycles, d lags exec by exactly one cycle.
REQ-037 out_ready low for 5 cycles on word 0 and word 3 -> update stays 1 until word 0 accepted, outr only on accepts, sequence unchanged.
REQ-038 start pulsed during EXEC -> ignored; pass completes normally.
REQ-039 reset asserted in LOAD at word 20 and in OUT at word 2 -> next cycle all outputs at reset values; a fresh reload=1 pass gives REQ-034 results.
